// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor controller.
// Contents:
//   bp_ctr_t     - 2-bit saturating branch counter
//   bp_state_t   - controller state (INIT sweep, RUN)
//   BP_CTR_INIT  - value every counter holds after the sweep (weakly not taken)
//   BP_IDX_W     - index field width carried in a queue entry (>= INDEX_BITS)
//   bp_qentry_t  - one outstanding prediction {idx, pred}
//   bp_next()    - counter training rule
package bp_pkg;

    typedef logic [1:0] bp_ctr_t;

    typedef enum logic {INIT, RUN} bp_state_t;

    localparam bp_ctr_t BP_CTR_INIT = 2'b01;

    // Queue entries carry a fixed-width index so the struct does not depend
    // on the table size; the top truncates it back to INDEX_BITS.
    localparam int BP_IDX_W = 16;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                pred;
    } bp_qentry_t;

    // Saturating update: move toward 11 on taken, toward 00 on not taken.
    function automatic bp_ctr_t bp_next(bp_ctr_t q, logic taken);
        bp_ctr_t n;
        case (q)
            2'b00:   n = taken ? 2'b01 : 2'b00;
            2'b01:   n = taken ? 2'b10 : 2'b00;
            2'b10:   n = taken ? 2'b11 : 2'b01;
            default: n = taken ? 2'b11 : 2'b10;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Fetch/resolve bus between the pipeline and the branch predictor controller.
// Signals:
//   fetch_valid, fetch_is_branch, fetch_pc  - fetch request (pipeline -> predictor)
//   fetch_ready, predict_taken              - acceptance and prediction (predictor -> pipeline)
//   resolve_valid, resolve_taken            - oldest branch outcome (pipeline -> predictor)
//   mispredict                              - one-cycle squash pulse (predictor -> pipeline)
//   branch_count, mispredict_count          - statistics (predictor -> pipeline)
// Modports: master = pipeline side, slave = predictor side.
interface branch_predict_ctrl_if #(
    parameter int PC_WIDTH = 32
);

    logic                fetch_valid;
    logic                fetch_is_branch;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                fetch_ready;
    logic                predict_taken;
    logic                resolve_valid;
    logic                resolve_taken;
    logic                mispredict;
    logic [15:0]         branch_count;
    logic [15:0]         mispredict_count;

    modport master (
        output fetch_valid, fetch_is_branch, fetch_pc, resolve_valid, resolve_taken,
        input  fetch_ready, predict_taken, mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  fetch_valid, fetch_is_branch, fetch_pc, resolve_valid, resolve_taken,
        output fetch_ready, predict_taken, mispredict, branch_count, mispredict_count
    );

endinterface

// File: rtl/bp_queue.sv
// In-order FIFO of outstanding predictions.
// Ports:
//   clock, clear      - clock and asynchronous active-high reset
//   push, pushData    - append an entry (ignored when full)
//   pop               - drop the head entry (ignored when empty)
//   flush             - discard every entry; wins over push
//   head              - oldest entry
//   full, empty       - occupancy status
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module bp_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  bp_qentry_t pushData,
    output bp_qentry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    bp_qentry_t       mem_q [DEPTH];

    logic doPush;
    logic doPop;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = mem_q[rdPtr_q];

    // Pointer and occupancy bookkeeping; a flush returns everything to empty.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: nothing is read until it has been pushed.
    always_ff @(posedge clock) begin
        if (doPush && !flush) mem_q[wrPtr_q] <= pushData;
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor controller: a table of 2-bit saturating counters shared by
// fetch (lookup) and execute (resolve). After reset the table is swept to
// weakly-not-taken; outstanding predictions wait in an in-order queue; each
// resolve trains its counter and flags a mispredict so younger fetches can be
// squashed.
// Ports:
//   clock  - rising-edge clock
//   clear  - asynchronous active-high reset
//   bus    - branch_predict_ctrl_if.slave (fetch, resolve, mispredict, stats)
// Optional feature: define BP_STATS_EN to build saturating 16-bit branch and
// mispredict counters; without it both statistics outputs are tied to zero.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INDEX_BITS  = 6,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    branch_predict_ctrl_if.slave  bus
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    bp_state_t             state_q, state_d;
    logic [INDEX_BITS-1:0] sweepIdx_q, sweepIdx_d;
    bp_ctr_t               table_q [ENTRIES];
    logic                  mispredict_q;

    logic [PC_WIDTH-1:0]   fetchPc;
    logic [INDEX_BITS-1:0] fetchIdx;
    logic [INDEX_BITS-1:0] headIdx;
    logic                  fetchReady;
    logic                  predictTaken;
    logic                  doPush;
    logic                  doPop;
    logic                  mispredictNow;
    logic                  qFull;
    logic                  qEmpty;
    bp_qentry_t            qHead;
    bp_qentry_t            pushEntry;

    logic                  tableWe;
    logic [INDEX_BITS-1:0] tableWaddr;
    bp_ctr_t               tableWdata;

    logic                  unusedBits;

    assign fetchPc  = bus.fetch_pc;
    assign fetchIdx = fetchPc[INDEX_BITS+1:2];
    assign headIdx  = qHead.idx[INDEX_BITS-1:0];

    // Only a slice of the PC and of the entry index field selects a counter.
    assign unusedBits = ^{fetchPc, qHead.idx};

    // fetch_ready depends on registered state only, never on resolve_valid.
    assign fetchReady    = (state_q == RUN) && !qFull;
    assign predictTaken  = (state_q == RUN) && table_q[fetchIdx][1];
    assign doPush        = bus.fetch_valid && bus.fetch_is_branch && fetchReady;
    assign doPop         = (state_q == RUN) && bus.resolve_valid && !qEmpty;
    assign mispredictNow = doPop && (bus.resolve_taken != qHead.pred);

    assign pushEntry.idx  = BP_IDX_W'(fetchIdx);
    assign pushEntry.pred = predictTaken;

    // A mispredict flushes the queue, which also swallows a same-cycle push.
    bp_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock    (clock),
        .clear    (clear),
        .push     (doPush),
        .pop      (doPop),
        .flush    (mispredictNow),
        .pushData (pushEntry),
        .head     (qHead),
        .full     (qFull),
        .empty    (qEmpty)
    );

    // Next state and the single table write port: the sweep owns it in INIT,
    // resolve training owns it in RUN.
    always_comb begin
        state_d    = state_q;
        sweepIdx_d = sweepIdx_q;
        tableWe    = 1'b0;
        tableWaddr = sweepIdx_q;
        tableWdata = BP_CTR_INIT;
        case (state_q)
            INIT: begin
                tableWe    = 1'b1;
                sweepIdx_d = sweepIdx_q + INDEX_BITS'(1);
                if (sweepIdx_q == '1) state_d = RUN;
            end
            RUN: begin
                if (doPop) begin
                    tableWe    = 1'b1;
                    tableWaddr = headIdx;
                    tableWdata = bp_next(table_q[headIdx], bus.resolve_taken);
                end
            end
        endcase
    end

    // State, sweep index and the registered mispredict pulse.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= INIT;
            sweepIdx_q   <= '0;
            mispredict_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweepIdx_q   <= sweepIdx_d;
            mispredict_q <= mispredictNow;
        end
    end

    // Counter table: reads are combinational, so a same-index lookup in the
    // update cycle still sees the old value.
    always_ff @(posedge clock) begin
        if (tableWe) table_q[tableWaddr] <= tableWdata;
    end

`ifdef BP_STATS_EN
    logic [15:0] branchCount_q;
    logic [15:0] mispCount_q;

    // Saturating statistics; untouched by a mispredict flush.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            branchCount_q <= '0;
            mispCount_q   <= '0;
        end else begin
            if (doPop && (branchCount_q != 16'hFFFF))
                branchCount_q <= branchCount_q + 16'd1;
            if (mispredictNow && (mispCount_q != 16'hFFFF))
                mispCount_q <= mispCount_q + 16'd1;
        end
    end

    assign bus.branch_count     = branchCount_q;
    assign bus.mispredict_count = mispCount_q;
`else
    assign bus.branch_count     = 16'h0000;
    assign bus.mispredict_count = 16'h0000;
`endif

    assign bus.fetch_ready   = fetchReady;
    assign bus.predict_taken = predictTaken;
    assign bus.mispredict    = mispredict_q;

endmodule
